// File: rtl/kb_scr_term_if.sv
// kb_scr_term_if: host keyboard/screen streams and the byte-wide device link of the terminal peer.
interface kb_scr_term_if;
    logic [7:0] kb_data_i;
    logic       kb_valid_i;
    logic       kb_ready_o;
    logic [7:0] scr_data_o;
    logic       scr_valid_o;
    logic       scr_ready_i;
    logic [7:0] dev_data_o;
    logic [7:0] dev_data_i;
    logic [1:0] dev_ctrl_o;
    logic [1:0] dev_ctrl_i;
    modport master (
        input  kb_data_i, kb_valid_i, scr_ready_i, dev_data_i, dev_ctrl_i,
        output kb_ready_o, scr_data_o, scr_valid_o, dev_data_o, dev_ctrl_o
    );
    modport slave (
        output kb_data_i, kb_valid_i, scr_ready_i, dev_data_i, dev_ctrl_i,
        input  kb_ready_o, scr_data_o, scr_valid_o, dev_data_o, dev_ctrl_o
    );
endinterface

// File: rtl/kb_scr_term.sv
// kb_scr_term: terminal-side link peer; buffered keyboard send (write_en/write_ok) and screen receive (read_en/read_ok).
module kb_scr_term #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    kb_scr_term_if.master                 bus,
    input  logic                          clr_i,
    output logic                          tx_timeout_o,
    output logic                          rx_overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   kb_level_o,
    output logic [$clog2(FIFO_DEPTH):0]   scr_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_SETUP = 2'd1;
    localparam logic [1:0] TX_WAIT  = 2'd2;
    localparam logic [1:0] TX_REL   = 2'd3;
    localparam logic [0:0] RX_IDLE  = 1'b0;
    localparam logic [0:0] RX_WAIT  = 1'b1;

    logic [7:0]    kb_mem [FIFO_DEPTH];
    logic [AW-1:0] kb_wp, kb_rp;
    logic [LW-1:0] kb_cnt;
    logic          kb_push, kb_pop;
    logic [7:0]    scr_mem [FIFO_DEPTH];
    logic [AW-1:0] scr_wp, scr_rp;
    logic [LW-1:0] scr_cnt;
    logic          scr_push, scr_pop;
    logic [1:0]    tx_st;
    logic [TW-1:0] tmo;
    logic          wr_en, tx_set;
    logic [7:0]    dout;
    logic [0:0]    rx_st;
    logic          rd_seen, rd_ok, capture, rx_set;

    assign bus.kb_ready_o  = kb_cnt != FULL;
    assign bus.scr_valid_o = scr_cnt != '0;
    assign bus.scr_data_o  = scr_mem[scr_rp];
    assign bus.dev_data_o  = dout;
    assign bus.dev_ctrl_o  = {wr_en, rd_ok};
    assign kb_level_o      = kb_cnt;
    assign scr_level_o     = scr_cnt;

    assign kb_push = bus.kb_valid_i && bus.kb_ready_o;
    assign kb_pop  = tx_st == TX_WAIT && !bus.dev_ctrl_i[0];
    assign tx_set  = tx_st == TX_WAIT && bus.dev_ctrl_i[0] && tmo == TW'(ACK_TIMEOUT - 1);

    // read_en must be low on two consecutive edges before the byte is trusted
    assign capture  = rx_st == RX_IDLE && rd_seen && !bus.dev_ctrl_i[1];
    assign scr_pop  = bus.scr_valid_o && bus.scr_ready_i;
    assign scr_push = capture && (scr_cnt != FULL || scr_pop);
    assign rx_set   = capture && !scr_push;

    always_ff @(posedge clk) begin
        if (kb_push)
            kb_mem[kb_wp] <= bus.kb_data_i;
        if (scr_push)
            scr_mem[scr_wp] <= ~bus.dev_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kb_wp   <= '0;
            kb_rp   <= '0;
            kb_cnt  <= '0;
            scr_wp  <= '0;
            scr_rp  <= '0;
            scr_cnt <= '0;
        end else begin
            kb_wp   <= kb_push ? kb_wp + 1'b1 : kb_wp;
            kb_rp   <= kb_pop ? kb_rp + 1'b1 : kb_rp;
            kb_cnt  <= kb_cnt + LW'(kb_push) - LW'(kb_pop);
            scr_wp  <= scr_push ? scr_wp + 1'b1 : scr_wp;
            scr_rp  <= scr_pop ? scr_rp + 1'b1 : scr_rp;
            scr_cnt <= scr_cnt + LW'(scr_push) - LW'(scr_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_st        <= TX_IDLE;
            wr_en        <= 1'b0;
            tmo          <= '0;
            dout         <= 8'h00;
            tx_timeout_o <= 1'b0;
        end else begin
            tx_timeout_o <= tx_set ? 1'b1 : clr_i ? 1'b0 : tx_timeout_o;
            case (tx_st)
                TX_IDLE:
                    if (kb_cnt != '0) begin
                        dout  <= kb_mem[kb_rp];
                        tx_st <= TX_SETUP;
                    end
                TX_SETUP: begin
                    wr_en <= 1'b1;
                    tx_st <= TX_WAIT;
                end
                TX_WAIT:
                    if (!bus.dev_ctrl_i[0]) begin
                        wr_en <= 1'b0;
                        tmo   <= '0;
                        tx_st <= TX_REL;
                    end else if (tx_set) begin
                        wr_en <= 1'b0;
                        tmo   <= '0;
                        tx_st <= TX_IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                default:
                    if (bus.dev_ctrl_i[0])
                        tx_st <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_st         <= RX_IDLE;
            rd_seen       <= 1'b0;
            rd_ok         <= 1'b0;
            rx_overflow_o <= 1'b0;
        end else begin
            rx_overflow_o <= rx_set ? 1'b1 : clr_i ? 1'b0 : rx_overflow_o;
            rd_ok         <= capture;
            rd_seen       <= rx_st == RX_IDLE && !bus.dev_ctrl_i[1] && !rd_seen;
            rx_st         <= capture ? RX_WAIT : (rx_st == RX_WAIT && bus.dev_ctrl_i[1]) ? RX_IDLE : rx_st;
        end
    end
endmodule

// File: tb/tb_kb_scr_term.sv
// tb_kb_scr_term: directed bench for kb_scr_term with a background write_ok responder and read_ok pulse counter.
module tb_kb_scr_term;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    kb_scr_term_if ifc();
    logic       tx_to, rx_ov;
    logic [2:0] kb_lvl, scr_lvl;

    kb_scr_term #(.FIFO_DEPTH(4), .ACK_TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc), .clr_i(clr),
        .tx_timeout_o(tx_to), .rx_overflow_o(rx_ov),
        .kb_level_o(kb_lvl), .scr_level_o(scr_lvl)
    );

    int checks = 0;
    int errors = 0;
    logic       wr_ok = 1'b1;
    logic       rd_en = 1'b1;
    logic [7:0] rd_data = 8'h00;
    assign ifc.dev_ctrl_i = {rd_en, wr_ok};
    assign ifc.dev_data_i = rd_data;

    logic       ack_en = 1'b1;
    int         ack_delay = 3;
    int         wcnt = 0;
    int         got_n = 0;
    int         stab_err = 0;
    int         rok_cnt = 0;
    logic [7:0] wbyte = 8'h00;
    logic [7:0] got [64];

    // driver-side responder: acks write_en after ack_delay high cycles, releases when write_en drops
    always @(negedge clk) begin
        if (ifc.dev_ctrl_o[1]) begin
            if (wcnt == 0) wbyte = ifc.dev_data_o;
            else if (ifc.dev_data_o !== wbyte) stab_err++;
            wcnt++;
            if (ack_en && wcnt >= ack_delay && wr_ok) begin
                wr_ok = 1'b0;
                got[got_n % 64] = wbyte;
                got_n++;
            end
        end else begin
            wcnt = 0;
            wr_ok = 1'b1;
        end
    end

    always @(negedge clk) if (ifc.dev_ctrl_o[0]) rok_cnt++;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_scr(input logic [7:0] b);
        rd_data = ~b;
        rd_en = 1'b0;
        tick(4);
        rd_en = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++; if (ifc.kb_ready_o !== 1'b1) begin errors++; $display("FAIL reset_kb_ready got=%b exp=1", ifc.kb_ready_o); end
        checks++; if (ifc.scr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_scr_valid got=%b exp=0", ifc.scr_valid_o); end
        checks++; if (ifc.dev_ctrl_o !== 2'b00) begin errors++; $display("FAIL reset_dev_ctrl got=%b exp=00", ifc.dev_ctrl_o); end
        checks++; if (ifc.dev_data_o !== 8'h00) begin errors++; $display("FAIL reset_dev_data got=%h exp=00", ifc.dev_data_o); end
        checks++; if (kb_lvl !== 3'd0 || scr_lvl !== 3'd0) begin errors++; $display("FAIL reset_levels got=%0d/%0d exp=0/0", kb_lvl, scr_lvl); end
        checks++; if (tx_to !== 1'b0 || rx_ov !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", tx_to, rx_ov); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_send();
        int base, n, hi;
        ack_en = 1'b1;
        ack_delay = 3;
        base = got_n;
        ifc.kb_data_i = 8'h41;
        ifc.kb_valid_i = 1'b1;
        tick();
        ifc.kb_valid_i = 1'b0;
        checks++; if (kb_lvl !== 3'd1) begin errors++; $display("FAIL send_level_after_push got=%0d exp=1", kb_lvl); end
        n = 0;
        while (!ifc.dev_ctrl_o[1] && n < 20) begin tick(); n++; end
        checks++; if (ifc.dev_ctrl_o[1] !== 1'b1) begin errors++; $display("FAIL send_write_en_rise got=%b exp=1", ifc.dev_ctrl_o[1]); end
        checks++; if (ifc.dev_data_o !== 8'h41) begin errors++; $display("FAIL send_dev_data got=%h exp=41", ifc.dev_data_o); end
        hi = 0;
        while (ifc.dev_ctrl_o[1] && hi < 400) begin hi++; tick(); end
        checks++; if (hi != 3) begin errors++; $display("FAIL send_write_en_len got=%0d exp=3", hi); end
        checks++; if (kb_lvl !== 3'd0) begin errors++; $display("FAIL send_level_after_ack got=%0d exp=0", kb_lvl); end
        checks++; if (got_n != base + 1 || got[base % 64] !== 8'h41) begin errors++; $display("FAIL send_delivered got=%0d/%h exp=%0d/41", got_n, got[base % 64], base + 1); end
        checks++; if (tx_to !== 1'b0 || stab_err != 0) begin errors++; $display("FAIL send_timeout_stable got=%b/%0d exp=0/0", tx_to, stab_err); end
        tick(2);
    endtask

    task automatic test_no_ack();
        int base, n, hi;
        ack_en = 1'b0;
        base = got_n;
        ifc.kb_data_i = 8'h5A;
        ifc.kb_valid_i = 1'b1;
        tick();
        ifc.kb_valid_i = 1'b0;
        n = 0;
        while (!ifc.dev_ctrl_o[1] && n < 20) begin tick(); n++; end
        hi = 0;
        while (ifc.dev_ctrl_o[1] && hi < 400) begin hi++; tick(); end
        checks++; if (hi != 255) begin errors++; $display("FAIL noack_write_en_len got=%0d exp=255", hi); end
        checks++; if (tx_to !== 1'b1) begin errors++; $display("FAIL noack_timeout_flag got=%b exp=1", tx_to); end
        checks++; if (kb_lvl !== 3'd1) begin errors++; $display("FAIL noack_byte_kept got=%0d exp=1", kb_lvl); end
        n = 0;
        while (!ifc.dev_ctrl_o[1] && n < 10) begin tick(); n++; end
        checks++; if (ifc.dev_ctrl_o[1] !== 1'b1 || ifc.dev_data_o !== 8'h5A) begin errors++; $display("FAIL noack_retry got=%b/%h exp=1/5a", ifc.dev_ctrl_o[1], ifc.dev_data_o); end
        ack_en = 1'b1;
        ack_delay = 1;
        n = 0;
        while (ifc.dev_ctrl_o[1] && n < 20) begin tick(); n++; end
        tick(2);
        checks++; if (got_n != base + 1 || got[base % 64] !== 8'h5A || kb_lvl !== 3'd0) begin errors++; $display("FAIL noack_retry_delivered got=%0d/%h/%0d exp=%0d/5a/0", got_n, got[base % 64], kb_lvl, base + 1); end
        checks++; if (tx_to !== 1'b1) begin errors++; $display("FAIL noack_flag_sticky got=%b exp=1", tx_to); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (tx_to !== 1'b0) begin errors++; $display("FAIL noack_clear got=%b exp=0", tx_to); end
        ack_delay = 3;
    endtask

    task automatic test_screen_rx();
        int base;
        base = rok_cnt;
        ifc.scr_ready_i = 1'b0;
        rd_data = ~8'h41;
        rd_en = 1'b0;
        tick(8);
        checks++; if (rok_cnt - base != 1) begin errors++; $display("FAIL rx_one_pulse got=%0d exp=1", rok_cnt - base); end
        checks++; if (scr_lvl !== 3'd1 || ifc.scr_valid_o !== 1'b1) begin errors++; $display("FAIL rx_level got=%0d/%b exp=1/1", scr_lvl, ifc.scr_valid_o); end
        checks++; if (ifc.scr_data_o !== 8'h41) begin errors++; $display("FAIL rx_data got=%h exp=41", ifc.scr_data_o); end
        rd_en = 1'b1;
        tick(2);
        rd_data = ~8'h42;
        rd_en = 1'b0;
        tick(4);
        rd_en = 1'b1;
        tick(2);
        checks++; if (rok_cnt - base != 2 || scr_lvl !== 3'd2) begin errors++; $display("FAIL rx_second got=%0d/%0d exp=2/2", rok_cnt - base, scr_lvl); end
        ifc.scr_ready_i = 1'b1;
        checks++; if (ifc.scr_data_o !== 8'h41) begin errors++; $display("FAIL rx_pop0 got=%h exp=41", ifc.scr_data_o); end
        tick();
        checks++; if (ifc.scr_data_o !== 8'h42) begin errors++; $display("FAIL rx_pop1 got=%h exp=42", ifc.scr_data_o); end
        tick();
        ifc.scr_ready_i = 1'b0;
        checks++; if (scr_lvl !== 3'd0 || ifc.scr_valid_o !== 1'b0) begin errors++; $display("FAIL rx_drained got=%0d/%b exp=0/0", scr_lvl, ifc.scr_valid_o); end
    endtask

    task automatic test_overflow();
        int base;
        base = rok_cnt;
        ifc.scr_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_scr(8'(i));
            if (i == 4) begin
                checks++; if (scr_lvl !== 3'd4 || rx_ov !== 1'b0) begin errors++; $display("FAIL ovf_full got=%0d/%b exp=4/0", scr_lvl, rx_ov); end
            end
        end
        checks++; if (rx_ov !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", rx_ov); end
        checks++; if (scr_lvl !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", scr_lvl); end
        checks++; if (rok_cnt - base != 5) begin errors++; $display("FAIL ovf_acks got=%0d exp=5", rok_cnt - base); end
        ifc.scr_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (ifc.scr_data_o !== 8'(i + 1)) begin errors++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, ifc.scr_data_o, 8'(i + 1)); end
            tick();
        end
        ifc.scr_ready_i = 1'b0;
        checks++; if (scr_lvl !== 3'd0) begin errors++; $display("FAIL ovf_drained got=%0d exp=0", scr_lvl); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (rx_ov !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", rx_ov); end
    endtask

    task automatic test_back_to_back();
        int base, n, full_bad;
        logic saw_full;
        ack_en = 1'b1;
        ack_delay = 2;
        base = got_n;
        saw_full = 1'b0;
        full_bad = 0;
        ifc.scr_ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    ifc.kb_data_i = 8'(8'h10 + i);
                    ifc.kb_valid_i = 1'b1;
                    n = 0;
                    while (!ifc.kb_ready_o && n < 100) begin
                        saw_full = 1'b1;
                        if (kb_lvl !== 3'd4) full_bad++;
                        tick();
                        n++;
                    end
                    tick();
                end
                ifc.kb_valid_i = 1'b0;
            end
            begin
                for (int j = 0; j < 3; j++) send_scr(8'(8'hA0 + j));
            end
        join
        n = 0;
        while (got_n < base + 10 && n < 400) begin tick(); n++; end
        checks++; if (got_n != base + 10) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_n - base, 10); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (got[(base + i) % 64] !== 8'(8'h10 + i)) begin errors++; $display("FAIL b2b_order%0d got=%h exp=%h", i, got[(base + i) % 64], 8'(8'h10 + i)); end
        end
        checks++; if (saw_full !== 1'b1 || full_bad != 0) begin errors++; $display("FAIL b2b_ready_at_full got=%b/%0d exp=1/0", saw_full, full_bad); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL b2b_data_stable got=%0d exp=0", stab_err); end
        checks++; if (scr_lvl !== 3'd3) begin errors++; $display("FAIL b2b_scr_level got=%0d exp=3", scr_lvl); end
        ifc.scr_ready_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            checks++; if (ifc.scr_data_o !== 8'(8'hA0 + j)) begin errors++; $display("FAIL b2b_scr%0d got=%h exp=%h", j, ifc.scr_data_o, 8'(8'hA0 + j)); end
            tick();
        end
        ifc.scr_ready_i = 1'b0;
        tick(3);
        ack_delay = 3;
    endtask

    task automatic test_reset_mid();
        int n;
        ack_en = 1'b0;
        ifc.scr_ready_i = 1'b0;
        send_scr(8'h33);
        ifc.kb_data_i = 8'h77;
        ifc.kb_valid_i = 1'b1;
        tick();
        ifc.kb_valid_i = 1'b0;
        n = 0;
        while (!ifc.dev_ctrl_o[1] && n < 20) begin tick(); n++; end
        tick(3);
        checks++; if (ifc.dev_ctrl_o[1] !== 1'b1 || ifc.dev_data_o !== 8'h77 || scr_lvl !== 3'd1) begin errors++; $display("FAIL rstmid_pre got=%b/%h/%0d exp=1/77/1", ifc.dev_ctrl_o[1], ifc.dev_data_o, scr_lvl); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (ifc.dev_ctrl_o !== 2'b00 || ifc.dev_data_o !== 8'h00) begin errors++; $display("FAIL rstmid_dev got=%b/%h exp=00/00", ifc.dev_ctrl_o, ifc.dev_data_o); end
        checks++; if (kb_lvl !== 3'd0 || scr_lvl !== 3'd0) begin errors++; $display("FAIL rstmid_levels got=%0d/%0d exp=0/0", kb_lvl, scr_lvl); end
        checks++; if (tx_to !== 1'b0 || rx_ov !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b%b exp=00", tx_to, rx_ov); end
        ack_en = 1'b1;
        tick(4);
        checks++; if (ifc.dev_ctrl_o[1] !== 1'b0) begin errors++; $display("FAIL rstmid_no_resend got=%b exp=0", ifc.dev_ctrl_o[1]); end
    endtask

    initial begin
        ifc.kb_data_i = 8'h00;
        ifc.kb_valid_i = 1'b0;
        ifc.scr_ready_i = 1'b0;
        tick();
        test_reset();
        test_single_send();
        test_no_ack();
        test_screen_rx();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
